multi_debounce: RTL and testbench
=================================

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter N_CH, default 5, number of independent button channels (1..32).
REQ-002 Parameter N_DC, default 25, qualify/release counter width; thresholds use counter bit N_DC-2.
REQ-003 Parameter HOLD_CYC, default 2**24, cycles in HELD before the first auto-repeat pulse.
REQ-004 Parameter RPT_CYC, default 2**22, cycles between subsequent auto-repeat pulses.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset; asynchronous and active-low.
REQ-007 btn_in  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 clean  output  N_CH  debounced level per channel.
REQ-009 single  output  N_CH  one-cycle press pulse per qualified press.
REQ-010 rpt  output  N_CH  one-cycle auto-repeat pulse while held.
REQ-011 any_single  output  1  OR-reduction of single.

Function
REQ-012 Each btn_in bit SHALL pass a 2-flop synchronizer; all FSM decisions use the synchronized level btn_s.
REQ-013 Each channel SHALL run an independent FSM: IDLE, WAIT_QUAL, PULSE, HELD, WAIT_REL.
REQ-014 IDLE: cnt<=0; btn_s=1 -> WAIT_QUAL.
REQ-015 WAIT_QUAL: cnt<=cnt+1; btn_s=0 -> IDLE (priority); else cnt[N_DC-2]=1 -> PULSE.
REQ-016 PULSE: cnt<=0; unconditionally -> HELD next cycle.
REQ-017 HELD: cnt<=0; btn_s=0 -> WAIT_REL.
REQ-018 WAIT_REL: cnt<=cnt+1; btn_s=1 -> HELD (priority, no new single); else cnt[N_DC-2]=1 -> IDLE.
REQ-019 clean SHALL be 1 in PULSE, HELD, WAIT_REL; single SHALL be 1 only in PULSE; both decoded from state with no extra latency.
REQ-020 Press latency: single asserts after the 8th rising edge following btn_in rise when N_DC=4 (2 sync + 1 IDLE + 5 WAIT_QUAL).
REQ-021 cnt SHALL be N_DC bits and never wrap in practice; qualification occurs when bit N_DC-2 first reads 1.
REQ-022 Channels SHALL NOT interact; simultaneous presses produce simultaneous independent pulses.
REQ-023 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 rst_n=0 SHALL asynchronously force all FSMs to IDLE, all counters and synchronizer flops to 0, and clean, single, rpt, any_single to 0.
REQ-025 Reset mid-press SHALL drop clean immediately; after release of rst_n a still-held button re-qualifies from IDLE and produces a new single.

Configuration
REQ-026 Macro DEBOUNCE_REPEAT_EN SHALL compile in auto-repeat.
REQ-027 With it: per-channel repeat counter cleared on every HELD entry; rpt pulses one cycle after HOLD_CYC cycles in HELD, then every RPT_CYC cycles; counter cleared and no rpt outside HELD.
REQ-028 Without it: rpt SHALL be constant 0 and no repeat counters synthesized.

Structure
REQ-029 Package debounce_pkg SHALL hold the state typedef and encodings (IDLE 3'b000, WAIT_QUAL 3'b001, PULSE 3'b110, HELD 3'b100, WAIT_REL 3'b101, clean=bit2, single=bit1).
REQ-030 One sub-module debounce_ch (synchronizer, FSM, counters for one channel) SHALL be instantiated N_CH times by generate.

Verification (N_CH=2, N_DC=4, HOLD_CYC=8, RPT_CYC=4)
REQ-031 Reset, btn_in[0] held high -> single[0]=1 for exactly one cycle after edge 8, clean[0]=1 thereafter, channel 1 all 0.
REQ-032 btn_in[0] high 3 cycles then low -> clean, single, rpt stay 0.
REQ-033 Qualified press, release 3 cycles, re-press -> clean[0] stays 1, no second single; release held 6 cycles -> clean[0] returns 0.
REQ-034 Held 30 cycles with DEBOUNCE_REPEAT_EN -> rpt[0] pulses 8, 12, 16, 20, 24, 28 cycles after HELD entry; without macro rpt stays 0.
REQ-035 rst_n driven low mid-HELD between clock edges -> clean[0]=0 before the next edge; after rst_n high, held button yields a fresh single at edge 8.
REQ-036 Both channels pressed the same cycle -> single=2'b11 and any_single=1 in the same single cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
`timescale 1ns/1ps
// debounce_pkg: shared state encoding and helpers for the multi-channel
// button debouncer. The encodings let clean and single be read directly from
// state bits, so both outputs come straight out of the state flops with no
// decode delay.
package debounce_pkg;

  // Per-channel debounce states; bit 2 = debounced level, bit 1 = press pulse
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WAIT_QUAL = 3'b001,
    PULSE     = 3'b110,
    HELD      = 3'b100,
    WAIT_REL  = 3'b101
  } state_t;

  localparam int CLEAN_BIT  = 2;
  localparam int SINGLE_BIT = 1;

  // Width needed to hold values 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
`timescale 1ns/1ps
// debounce_ch: one button channel. A 2-flop synchronizer feeds a five-state
// debounce FSM; a press must stay stable until counter bit N_DC-2 sets before
// it is accepted, and a release must do the same before clean drops.
// Optional auto-repeat is compiled in with the macro DEBOUNCE_REPEAT_EN;
// without it rpt is tied low and no repeat counter exists.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int N_DC     = 25,
  parameter int HOLD_CYC = 2**24,
  parameter int RPT_CYC  = 2**22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic clean,
  output logic single,
  output logic rpt
);

  // The repeat counter reloads to HOLD_CYC-RPT_CYC after the first pulse,
  // so the repeat period cannot exceed the initial hold time.
  if (N_DC < 2 || HOLD_CYC < 1 || RPT_CYC < 1 || RPT_CYC > HOLD_CYC) begin : g_bad_cfg
    $error("debounce_ch: need N_DC >= 2 and 1 <= RPT_CYC <= HOLD_CYC");
  end

  logic             sync_q1;
  logic             btn_s;
  state_t           state;
  logic [N_DC-1:0]  cnt;

  // Two-flop synchronizer for the asynchronous raw button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      btn_s   <= sync_q1;
    end
  end

  // Debounce FSM with its qualify/release stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) state <= WAIT_QUAL;
        end
        WAIT_QUAL: begin
          cnt <= cnt + N_DC'(1);
          if (!btn_s)            state <= IDLE;
          else if (cnt[N_DC-2])  state <= PULSE;
        end
        PULSE: begin
          cnt   <= '0;
          state <= HELD;
        end
        HELD: begin
          cnt <= '0;
          if (!btn_s) state <= WAIT_REL;
        end
        WAIT_REL: begin
          cnt <= cnt + N_DC'(1);
          if (btn_s)             state <= HELD;
          else if (cnt[N_DC-2])  state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign clean  = state[CLEAN_BIT];
  assign single = state[SINGLE_BIT];

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RW = cnt_width(HOLD_CYC);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(HOLD_CYC - RPT_CYC);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_q;

  // Auto-repeat timer: runs only while HELD, first fire after HOLD_CYC
  // cycles, then reloads so later fires come every RPT_CYC cycles. The pulse
  // is gated by btn_s so it never lands on a cycle where HELD is being left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt <= '0;
      rpt_q   <= 1'b0;
    end else if (state == HELD) begin
      if (rpt_cnt == RPT_FIRE) begin
        rpt_cnt <= RPT_RELOAD;
        rpt_q   <= btn_s;
      end else begin
        rpt_cnt <= rpt_cnt + RW'(1);
        rpt_q   <= 1'b0;
      end
    end else begin
      rpt_cnt <= '0;
      rpt_q   <= 1'b0;
    end
  end

  assign rpt = rpt_q;
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
`timescale 1ns/1ps
// multi_debounce: N_CH independent debounced button channels with press
// pulses, an OR of all press pulses, and optional auto-repeat (compiled in
// with the macro DEBOUNCE_REPEAT_EN).
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int N_CH     = 5,
  parameter int N_DC     = 25,
  parameter int HOLD_CYC = 2**24,
  parameter int RPT_CYC  = 2**22
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] single,
  output logic [N_CH-1:0] rpt,
  output logic            any_single
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("multi_debounce: N_CH must be in 1..32");
  end

  // One fully independent debouncer per button
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .N_DC     (N_DC),
      .HOLD_CYC (HOLD_CYC),
      .RPT_CYC  (RPT_CYC)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_in (btn_in[i]),
      .clean  (clean[i]),
      .single (single[i]),
      .rpt    (rpt[i])
    );
  end

  assign any_single = |single;

endmodule

// File: tb/tb_multi_debounce.sv
`timescale 1ns/1ps
// tb_multi_debounce: scoreboard bench for multi_debounce with N_CH=2, N_DC=4,
// HOLD_CYC=8, RPT_CYC=4. Each driven cycle pushes the expected outputs for
// the following edge; the entry is popped and compared once the DUT has
// updated. Expected timing: a press applied before edge 1 gives single at
// edge 8 and clean from edge 8; HELD starts at edge 9 so repeats land at
// edges 17, 21, 25, ... when DEBOUNCE_REPEAT_EN is defined. A release from
// HELD drops clean at the 8th edge after the release.
module tb_multi_debounce;

  localparam int N_CH = 2;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] clean;
    logic [1:0] single;
    logic [1:0] rpt;
    logic       any;
  } obs_t;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] single;
  logic [N_CH-1:0] rpt;
  logic            any_single;

  obs_t exp_q[$];
  int   n_checks;
  int   n_errors;

  multi_debounce #(
    .N_CH     (N_CH),
    .N_DC     (4),
    .HOLD_CYC (8),
    .RPT_CYC  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_in     (btn_in),
    .clean      (clean),
    .single     (single),
    .rpt        (rpt),
    .any_single (any_single)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mkExp(input logic [1:0] c, input logic [1:0] s,
                                 input logic [1:0] r);
    obs_t e;
    e.clean  = c;
    e.single = s;
    e.rpt    = r;
    e.any    = |s;
    return e;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.clean  = clean;
    o.single = single;
    o.rpt    = rpt;
    o.any    = any_single;
    return o;
  endfunction

  task automatic checkOutput(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got clean=%b single=%b rpt=%b any=%b, expected clean=%b single=%b rpt=%b any=%b",
               tag, got.clean, got.single, got.rpt, got.any,
               exp.clean, exp.single, exp.rpt, exp.any);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic applyStimulus(input logic [1:0] btn, input obs_t exp, input string tag);
    obs_t got;
    btn_in = btn;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = sampleDut();
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      checkOutput(tag, got, exp_q.pop_front());
    end
  endtask

  // Press from idle held for n edges, including expected repeat pulses
  task automatic pressPhase(input logic [1:0] mask, input int n, input string tag);
    logic [1:0] c, s, r;
    for (int k = 1; k <= n; k++) begin
      c = (k >= 8) ? mask : 2'b00;
      s = (k == 8) ? mask : 2'b00;
      r = (RPT_EN && k >= 17 && ((k - 17) % 4) == 0) ? mask : 2'b00;
      applyStimulus(mask, mkExp(c, s, r), $sformatf("%s_k%0d", tag, k));
    end
  endtask

  // Release from HELD for n edges; clean falls at the 8th edge
  task automatic releasePhase(input logic [1:0] mask, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      applyStimulus(2'b00, mkExp((k < 8) ? mask : 2'b00, 2'b00, 2'b00),
                    $sformatf("%s_r%0d", tag, k));
    end
  endtask

  // Re-press that catches WAIT_REL: stays clean, no new single
  task automatic repressPhase(input logic [1:0] mask, input int n, input string tag);
    for (int k = 1; k <= n; k++) begin
      applyStimulus(mask, mkExp(mask, 2'b00, 2'b00), $sformatf("%s_p%0d", tag, k));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_in   = 2'b11;

    // Reset: outputs low even with buttons pressed during reset
    #12;
    checkOutput("reset_async", sampleDut(), mkExp(2'b00, 2'b00, 2'b00));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", sampleDut(), mkExp(2'b00, 2'b00, 2'b00));
    @(negedge clk);
    btn_in = 2'b00;
    rst_n  = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(2'b00, mkExp(2'b00, 2'b00, 2'b00), "idle0");

    // Long hold on channel 0: single, clean, repeat train, release
    $display("[TB] long hold with auto-repeat on channel 0");
    pressPhase(2'b01, 38, "hold");
    releasePhase(2'b01, 10, "hold_rel");

    // Short glitch of 3 cycles must never qualify
    $display("[TB] short glitch");
    for (int k = 0; k < 3; k++) applyStimulus(2'b01, mkExp(2'b00, 2'b00, 2'b00), "glitch_hi");
    for (int k = 0; k < 10; k++) applyStimulus(2'b00, mkExp(2'b00, 2'b00, 2'b00), "glitch_lo");

    // Bounce on release: brief drop then re-press keeps clean, no new single
    $display("[TB] release bounce");
    pressPhase(2'b01, 12, "bounce_press");
    releasePhase(2'b01, 3, "bounce_short_rel");
    repressPhase(2'b01, 8, "bounce");
    releasePhase(2'b01, 12, "bounce_rel");

    // Asynchronous reset in the middle of HELD, then re-qualify
    $display("[TB] reset mid-hold");
    pressPhase(2'b01, 12, "prerst");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_async", sampleDut(), mkExp(2'b00, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    checkOutput("rst_mid_held", sampleDut(), mkExp(2'b00, 2'b00, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    pressPhase(2'b01, 12, "postrst");
    releasePhase(2'b01, 10, "postrst_rel");

    // Simultaneous presses on both channels
    $display("[TB] simultaneous press");
    pressPhase(2'b11, 12, "both");
    releasePhase(2'b11, 10, "both_rel");

    // Channel 1 alone, channel 0 must stay quiet
    $display("[TB] channel 1 alone");
    pressPhase(2'b10, 12, "ch1");
    releasePhase(2'b10, 10, "ch1_rel");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
